// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a + b + cin, one DIGIT-bit ripple slice per clock.
// Latency WIDTH/DIGIT + 1 edges from accepted start to done; start ignored while busy.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             c_msb;
  logic [WIDTH-1:0] s_full;
  logic             accept;
  logic             last;

  always_comb begin : slice_add
    logic c;
    c         = carry_q;
    c_msb     = carry_q;
    slice_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      slice_sum[i] = a_sh_q[i] ^ b_sh_q[i] ^ c;
      c = (a_sh_q[i] & b_sh_q[i]) | (c & (a_sh_q[i] ^ b_sh_q[i]));
    end
    slice_cout = c;
  end

  // Earlier slices sit in the top of s_sh; the current slice completes the word.
  if (DIGIT < WIDTH) begin : g_sh
    logic [WIDTH-DIGIT-1:0] s_sh_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 s_sh_q <= '0;
      else if (accept)         s_sh_q <= '0;
      else if (state_q == RUN) s_sh_q <= s_full[WIDTH-1:DIGIT];
    end
    assign s_full = {slice_sum, s_sh_q};
  end else begin : g_nosh
    assign s_full = slice_sum;
  end

  assign accept = start && (state_q == IDLE || state_q == DONE);
  assign last   = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        carry_d = slice_cout;
        if (last) begin
          state_d = DONE;
          sum_d   = s_full;
          cout_d  = slice_cout;
          ovf_d   = c_msb ^ slice_cout;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 for DIGIT = 1, 2, 4, 8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start_v = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;

  logic       busy_w [4];
  logic       done_w [4];
  logic [7:0] sum_w  [4];
  logic       cout_w [4];
  logic       ovf_w  [4];

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start_v[g]),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .sum      (sum_w[g]),
      .cout     (cout_w[g]),
      .overflow (ovf_w[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start for one cycle, then samples at each falling edge until done.
  // edges counts rising edges from the accepting one up to the done cycle.
  task automatic do_add(input int g, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, output int edges, output int bcnt);
    bit found = 0;
    a = av; b = bv; cin = ci; start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
    edges = 0; bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy_w[g]) bcnt++;
      if (done_w[g]) begin
        edges = k; found = 1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", 32'(found), 32'd1);
  endtask

  task automatic check_result(input int g, input logic [7:0] av, input logic [7:0] bv,
                              input logic ci);
    logic [8:0] ref_full;
    logic       ref_ovf;
    ref_full = {1'b0, av} + {1'b0, bv} + {8'd0, ci};
    ref_ovf  = (av[7] == bv[7]) && (ref_full[7] != av[7]);
    check("sum",      32'(sum_w[g]),  32'(ref_full[7:0]));
    check("cout",     32'(cout_w[g]), 32'(ref_full[8]));
    check("overflow", 32'(ovf_w[g]),  32'(ref_ovf));
  endtask

  initial begin
    int edges, bcnt, dcnt, cyc, t1, t2;
    logic [7:0] s1, s2, ra, rb;
    logic rc;

    // Reset state
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check("rst_busy", 32'(busy_w[g]), 0);
      check("rst_done", 32'(done_w[g]), 0);
      check("rst_sum",  32'(sum_w[g]),  0);
      check("rst_cout", 32'(cout_w[g]), 0);
      check("rst_ovf",  32'(ovf_w[g]),  0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 0xFF + 0x01, DIGIT=1
    do_add(0, 8'hFF, 8'h01, 1'b0, edges, bcnt);
    check("d1_edges", 32'(edges), 9);
    check("d1_busy_cycles", 32'(bcnt), 8);
    check("d1_sum", 32'(sum_w[0]), 32'h00);
    check("d1_cout", 32'(cout_w[0]), 1);
    check("d1_ovf", 32'(ovf_w[0]), 0);
    @(negedge clk);
    check("d1_done_one_cycle", 32'(done_w[0]), 0);
    check("d1_sum_hold", 32'(sum_w[0]), 32'h00);

    // 0x7F + 0x01 signed overflow
    do_add(0, 8'h7F, 8'h01, 1'b0, edges, bcnt);
    check("ov_sum", 32'(sum_w[0]), 32'h80);
    check("ov_cout", 32'(cout_w[0]), 0);
    check("ov_ovf", 32'(ovf_w[0]), 1);
    @(negedge clk);

    // DIGIT=4: 0xA5 + 0x5A + 1
    do_add(2, 8'hA5, 8'h5A, 1'b1, edges, bcnt);
    check("d4_edges", 32'(edges), 3);
    check("d4_sum", 32'(sum_w[2]), 32'h00);
    check("d4_cout", 32'(cout_w[2]), 1);
    check("d4_ovf", 32'(ovf_w[2]), 0);
    @(negedge clk);

    // DIGIT=8: single slice
    do_add(3, 8'h80, 8'h80, 1'b0, edges, bcnt);
    check("d8_edges", 32'(edges), 2);
    check("d8_sum", 32'(sum_w[3]), 32'h00);
    check("d8_ovf", 32'(ovf_w[3]), 1);
    @(negedge clk);

    // start during RUN ignored; operands may change freely
    a = 8'h10; b = 8'h20; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h77; cin = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    dcnt = 0; s1 = '0;
    for (int k = 0; k < 20; k++) begin
      if (done_w[0]) begin
        dcnt++;
        if (dcnt == 1) s1 = sum_w[0];
      end
      @(negedge clk);
    end
    check("ign_done_count", 32'(dcnt), 1);
    check("ign_sum", 32'(s1), 32'h30);

    // Reset in the middle of RUN
    a = 8'h55; b = 8'h22; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_w[0]), 0);
    check("arst_done", 32'(done_w[0]), 0);
    check("arst_sum",  32'(sum_w[0]),  0);
    check("arst_cout", 32'(cout_w[0]), 0);
    check("arst_ovf",  32'(ovf_w[0]),  0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done_w[0] || busy_w[0]) dcnt++;
      @(negedge clk);
    end
    check("arst_no_activity", 32'(dcnt), 0);
    do_add(0, 8'h03, 8'h04, 1'b0, edges, bcnt);
    check("post_rst_sum", 32'(sum_w[0]), 32'h07);
    @(negedge clk);

    // start held high: back-to-back, 1+1 then 2+2 presented in DONE
    a = 8'h01; b = 8'h01; cin = 1'b0; start_v[0] = 1'b1;
    dcnt = 0; cyc = 0; t1 = 0; t2 = 0; s1 = '0; s2 = '0;
    for (int k = 0; k < 40 && dcnt < 2; k++) begin
      @(negedge clk);
      cyc++;
      if (done_w[0]) begin
        dcnt++;
        if (dcnt == 1) begin
          t1 = cyc; s1 = sum_w[0];
          a = 8'h02; b = 8'h02;
        end else begin
          t2 = cyc; s2 = sum_w[0];
          start_v[0] = 1'b0;
        end
      end
    end
    start_v[0] = 1'b0;
    check("b2b_done_count", 32'(dcnt), 2);
    check("b2b_sum1", 32'(s1), 32'h02);
    check("b2b_sum2", 32'(s2), 32'h04);
    check("b2b_spacing", 32'(t2 - t1), 9);
    @(negedge clk);

    // Random regression, 250 operand sets per DIGIT
    for (int g = 0; g < 4; g++) begin
      for (int n = 0; n < 250; n++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 1'($urandom_range(0, 1));
        do_add(g, ra, rb, rc, edges, bcnt);
        check_result(g, ra, rb, rc);
      end
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
